cus43_tile_shifter: RTL and testbench

Per-layer tile pixel serializer sitting directly downstream of the CUS42 scroll/address stage. It captures tile ROM data fetched at the CUS42 `GA` address, plus the tile attribute byte read from tile SRAM. It double-buffers both and shifts out one 3-bit pixel index per `CLK_6M` along with the tile colour attribute. Its output feeds the layer priority/palette mixer; one instance is used per scroll layer.

---
 rtl/cus43_tile_shifter_pkg.sv | 62 ++++++
 rtl/cus43_plane_shifter.sv | 42 ++++
 rtl/cus43_tile_shifter.sv | 109 ++++++++++
 tb/tb_cus43_tile_shifter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cus43_tile_shifter_pkg.sv
// Shared types, widths and plane helpers for the CUS43 tile pixel serializer.
package cus43_tile_shifter_pkg;

  localparam int unsigned GROUP_PIXELS = 4;
  localparam int unsigned PIX_W        = 3;
  localparam int unsigned GDA_W        = 8;
  localparam int unsigned GDB_W        = 4;
  localparam int unsigned ATTR_W       = 8;
  localparam int unsigned CNT_W        = 3;

  localparam logic [PIX_W-1:0] TRANSPARENT_PEN_DEFAULT = 3'd7;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } shift_dir_t;

  // One 4-pixel group split into its three bit planes (p2 = MSB of the pen).
  typedef struct packed {
    logic [GROUP_PIXELS-1:0] p2;
    logic [GROUP_PIXELS-1:0] p1;
    logic [GROUP_PIXELS-1:0] p0;
  } planes_t;

  localparam planes_t PLANES_EMPTY = '1;

  // GDA carries planes 1 (upper nibble) and 0 (lower nibble); GDB is plane 2.
  function automatic planes_t pack_planes(input logic [GDA_W-1:0] gda,
                                          input logic [GDB_W-1:0] gdb);
    planes_t p;
    p.p2 = gdb;
    p.p1 = gda[GDA_W-1:GROUP_PIXELS];
    p.p0 = gda[GROUP_PIXELS-1:0];
    return p;
  endfunction

  // Advance one pixel; vacated bits fill with 1 so an exhausted group reads transparent.
  function automatic planes_t shift_planes(input planes_t p, input shift_dir_t dir);
    planes_t q;
    if (dir == DIR_LEFT) begin
      q.p2 = {p.p2[GROUP_PIXELS-2:0], 1'b1};
      q.p1 = {p.p1[GROUP_PIXELS-2:0], 1'b1};
      q.p0 = {p.p0[GROUP_PIXELS-2:0], 1'b1};
    end else begin
      q.p2 = {1'b1, p.p2[GROUP_PIXELS-1:1]};
      q.p1 = {1'b1, p.p1[GROUP_PIXELS-1:1]};
      q.p0 = {1'b1, p.p0[GROUP_PIXELS-1:1]};
    end
    return q;
  endfunction

  function automatic logic [PIX_W-1:0] tap_pixel(input planes_t p, input shift_dir_t dir);
    logic [PIX_W-1:0] px;
    if (dir == DIR_LEFT) begin
      px = {p.p2[GROUP_PIXELS-1], p.p1[GROUP_PIXELS-1], p.p0[GROUP_PIXELS-1]};
    end else begin
      px = {p.p2[0], p.p1[0], p.p0[0]};
    end
    return px;
  endfunction

endpackage

// File: rtl/cus43_plane_shifter.sv
// Four-pixel, three-plane shift register with per-group direction and pixel counter.
module cus43_plane_shifter
  import cus43_tile_shifter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  shift_dir_t       load_dir,
  input  planes_t          load_planes,
  output logic [PIX_W-1:0] pixel_c
);

  planes_t          sh;
  shift_dir_t       dir;
  logic [CNT_W-1:0] cnt;

  // Direction is latched at load so a mid-group flip waits for the next group.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= PLANES_EMPTY;
      dir <= DIR_LEFT;
      cnt <= '0;
    end else if (load) begin
      sh  <= load_planes;
      dir <= load_dir;
      cnt <= CNT_W'(GROUP_PIXELS);
    end else begin
      sh <= shift_planes(sh, dir);
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    pixel_c = '1;
    if (cnt != '0) begin
      pixel_c = tap_pixel(sh, dir);
    end
  end

endmodule

// File: rtl/cus43_tile_shifter.sv
// Per-layer tile serializer: holding registers, attribute pipeline and registered pixel output.
module cus43_tile_shifter
  import cus43_tile_shifter_pkg::*;
#(
  parameter logic             ASSIGNED_LAYER  = 1'b0,
  parameter logic [PIX_W-1:0] TRANSPARENT_PEN = TRANSPARENT_PEN_DEFAULT
) (
  input  logic              CLK_6M,
  input  logic              rst,
  input  logic              FLIP,
  input  logic              LAYER_EN,
  input  logic              nGLD,
  input  logic [GDA_W-1:0]  GDA,
  input  logic [GDB_W-1:0]  GDB,
  input  logic              NIB,
  input  logic              nALD,
  input  logic [ATTR_W-1:0] RD,
  input  logic              S3H,
  output logic [PIX_W-1:0]  DOT,
  output logic [ATTR_W-1:0] COL,
  output logic              OPAQUE,
  output logic              LAYER_ID
);

  logic [GDA_W-1:0]  gda_h;
  logic [GDB_W-1:0]  gdb_h;
  logic              nib_h;
  logic              hvalid;
  logic [ATTR_W-1:0] attr_h;
  logic [ATTR_W-1:0] attr_a;

  planes_t           load_planes_c;
  shift_dir_t        load_dir_c;
  logic [PIX_W-1:0]  pixel_c;
  logic [PIX_W-1:0]  next_dot_c;

  assign LAYER_ID = ASSIGNED_LAYER;

  // Holding stage; a fetch in the same clock as a transfer refills it for the next group.
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      gda_h  <= '0;
      gdb_h  <= '0;
      nib_h  <= 1'b0;
      hvalid <= 1'b0;
      attr_h <= '0;
    end else begin
      if (S3H) begin
        hvalid <= 1'b0;
      end
      if (!nGLD) begin
        gda_h  <= GDA;
        gdb_h  <= GDB;
        nib_h  <= NIB;
        hvalid <= 1'b1;
      end
      if (!nALD) begin
        attr_h <= RD;
      end
    end
  end

  // Attribute advances only when a valid first-half group is transferred.
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      attr_a <= '0;
    end else if (S3H && hvalid && !nib_h) begin
      attr_a <= attr_h;
    end
  end

  // An underrun transfers an empty group so the layer goes transparent instead of repeating.
  always_comb begin
    load_planes_c = PLANES_EMPTY;
    load_dir_c    = DIR_LEFT;
    next_dot_c    = TRANSPARENT_PEN;
    if (hvalid) begin
      load_planes_c = pack_planes(gda_h, gdb_h);
    end
    if (FLIP) begin
      load_dir_c = DIR_RIGHT;
    end
    if (LAYER_EN) begin
      next_dot_c = pixel_c;
    end
  end

  cus43_plane_shifter u_shifter (
    .clk         (CLK_6M),
    .rst         (rst),
    .load        (S3H),
    .load_dir    (load_dir_c),
    .load_planes (load_planes_c),
    .pixel_c     (pixel_c)
  );

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      DOT    <= TRANSPARENT_PEN;
      COL    <= '0;
      OPAQUE <= 1'b0;
    end else begin
      DOT    <= next_dot_c;
      COL    <= attr_a;
      OPAQUE <= (next_dot_c != TRANSPARENT_PEN);
    end
  end

endmodule

// File: tb/tb_cus43_tile_shifter.sv
// Self-checking bench: directed vector table, then random traffic against a group-level model.
module tb_cus43_tile_shifter;

  logic       CLK_6M = 1'b0;
  logic       rst = 1'b1;
  logic       FLIP = 1'b0;
  logic       LAYER_EN = 1'b1;
  logic       nGLD = 1'b1;
  logic [7:0] GDA = '0;
  logic [3:0] GDB = '0;
  logic       NIB = 1'b0;
  logic       nALD = 1'b1;
  logic [7:0] RD = '0;
  logic       S3H = 1'b0;
  logic [2:0] DOT;
  logic [7:0] COL;
  logic       OPAQUE;
  logic       LAYER_ID;

  always #5 CLK_6M = ~CLK_6M;

  cus43_tile_shifter dut (
    .CLK_6M   (CLK_6M),
    .rst      (rst),
    .FLIP     (FLIP),
    .LAYER_EN (LAYER_EN),
    .nGLD     (nGLD),
    .GDA      (GDA),
    .GDB      (GDB),
    .NIB      (NIB),
    .nALD     (nALD),
    .RD       (RD),
    .S3H      (S3H),
    .DOT      (DOT),
    .COL      (COL),
    .OPAQUE   (OPAQUE),
    .LAYER_ID (LAYER_ID)
  );

  typedef struct {
    logic       rst, s3h, ngld;
    logic [7:0] gda;
    logic [3:0] gdb;
    logic       nib, nald;
    logic [7:0] rd;
    logic       flip, en;
    logic [2:0] edot;
    logic [7:0] ecol;
    logic       eopq;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic row(input logic r, s, g, input logic [7:0] gda, input logic [3:0] gdb,
                     input logic nib, a, input logic [7:0] rd, input logic f, e,
                     input logic [2:0] dot, input logic [7:0] col, input logic opq);
    vec_t v;
    v.rst = r; v.s3h = s; v.ngld = g; v.gda = gda; v.gdb = gdb; v.nib = nib;
    v.nald = a; v.rd = rd; v.flip = f; v.en = e;
    v.edot = dot; v.ecol = col; v.eopq = opq;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, s, g, input logic [7:0] gda, input logic [3:0] gdb,
                       input logic nib, a, input logic [7:0] rd, input logic f, e);
    rst = r; S3H = s; nGLD = g; GDA = gda; GDB = gdb; NIB = nib;
    nALD = a; RD = rd; FLIP = f; LAYER_EN = e;
  endtask

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  // Pixel n of a group, leftmost first, straight from the ROM bit layout.
  function automatic logic [2:0] ref_pix(input logic [7:0] gda, input logic [3:0] gdb,
                                         input logic flip, input int n);
    int i;
    i = flip ? n : 3 - n;
    return {gdb[i], gda[4 + i], gda[i]};
  endfunction

  initial begin : main
    logic [2:0] m_grp [4];
    int         m_pos;
    logic [7:0] m_gda;
    logic [3:0] m_gdb;
    logic       m_nib, m_hv;
    logic [7:0] m_attr_h, m_attr_a;
    logic       r, s, g, nib, a, f, e;
    logic [7:0] gda, rd;
    logic [3:0] gdb;
    logic [2:0] cur, edot;
    logic [7:0] ecol;
    logic       eopq;

    //  r  s  g  gda    gdb   nib a  rd     f  e   dot col    opq
    row(1, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h00, 0);
    row(0, 0, 0, 8'hA5, 4'h9, 0, 0, 8'h3C, 0, 1, 7, 8'h00, 0);
    row(0, 1, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h00, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 6, 8'h3C, 1);
    row(0, 0, 0, 8'hA5, 4'h9, 1, 0, 8'h77, 1, 1, 1, 8'h3C, 1);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 1, 1, 2, 8'h3C, 1);
    row(0, 1, 1, 8'h00, 4'h0, 0, 1, 8'h00, 1, 1, 5, 8'h3C, 1);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 1, 1, 5, 8'h3C, 1);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 1, 1, 2, 8'h3C, 1);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 1, 1, 1, 8'h3C, 1);
    row(0, 1, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 6, 8'h3C, 1);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h3C, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h3C, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h3C, 0);
    row(0, 0, 0, 8'hFF, 4'hF, 0, 1, 8'h00, 0, 1, 7, 8'h3C, 0);
    row(0, 1, 0, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h3C, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h77, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h77, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h77, 0);
    row(0, 1, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h77, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 0, 8'h77, 1);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 0, 8'h77, 1);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 0, 8'h77, 1);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 0, 8'h77, 1);
    row(0, 0, 0, 8'hA5, 4'h9, 0, 1, 8'h00, 0, 1, 7, 8'h77, 0);
    row(0, 1, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h77, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 6, 8'h77, 1);
    row(1, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h00, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h00, 0);
    row(0, 0, 0, 8'hA5, 4'h9, 0, 1, 8'h00, 0, 1, 7, 8'h00, 0);
    row(0, 1, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 0, 7, 8'h00, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 0, 7, 8'h00, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 0, 7, 8'h00, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 2, 8'h00, 1);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 0, 7, 8'h00, 0);
    row(0, 0, 1, 8'h00, 4'h0, 0, 1, 8'h00, 0, 1, 7, 8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].s3h, tbl[i].ngld, tbl[i].gda, tbl[i].gdb,
            tbl[i].nib, tbl[i].nald, tbl[i].rd, tbl[i].flip, tbl[i].en);
      @(posedge CLK_6M);
      #1;
      check("vec_dot", i, int'(DOT), int'(tbl[i].edot));
      check("vec_col", i, int'(COL), int'(tbl[i].ecol));
      check("vec_opaque", i, int'(OPAQUE), int'(tbl[i].eopq));
    end
    check("layer_id", 0, int'(LAYER_ID), 0);

    // Random traffic; the model tracks whole groups as pixel arrays plus a read position.
    m_pos = 4; m_gda = '0; m_gdb = '0; m_nib = 1'b0; m_hv = 1'b0;
    m_attr_h = '0; m_attr_a = '0;
    for (int n = 0; n < 4; n++) m_grp[n] = 3'd7;
    for (int c = 0; c < 1500; c++) begin
      r   = (c == 0) || ($urandom_range(0, 49) == 0);
      s   = ($urandom_range(0, 3) == 0);
      g   = ($urandom_range(0, 2) != 0);
      a   = ($urandom_range(0, 3) != 0);
      nib = 1'($urandom_range(0, 1));
      f   = 1'($urandom_range(0, 1));
      e   = ($urandom_range(0, 7) != 0);
      gda = 8'($urandom());
      gdb = 4'($urandom());
      rd  = 8'($urandom());
      drive(r, s, g, gda, gdb, nib, a, rd, f, e);

      if (r) begin
        edot = 3'd7; ecol = 8'h00; eopq = 1'b0;
        m_pos = 4; m_gda = '0; m_gdb = '0; m_nib = 1'b0; m_hv = 1'b0;
        m_attr_h = '0; m_attr_a = '0;
        for (int n = 0; n < 4; n++) m_grp[n] = 3'd7;
      end else begin
        cur  = (m_pos < 4) ? m_grp[m_pos] : 3'd7;
        edot = e ? cur : 3'd7;
        ecol = m_attr_a;
        eopq = (edot != 3'd7);
        if (s) begin
          for (int n = 0; n < 4; n++) m_grp[n] = m_hv ? ref_pix(m_gda, m_gdb, f, n) : 3'd7;
          if (m_hv && !m_nib) m_attr_a = m_attr_h;
          m_pos = 0;
          m_hv  = 1'b0;
        end else if (m_pos < 4) begin
          m_pos++;
        end
        if (!g) begin
          m_gda = gda; m_gdb = gdb; m_nib = nib; m_hv = 1'b1;
        end
        if (!a) m_attr_h = rd;
      end

      @(posedge CLK_6M);
      #1;
      check("rnd_dot", c, int'(DOT), int'(edot));
      check("rnd_col", c, int'(COL), int'(ecol));
      check("rnd_opaque", c, int'(OPAQUE), int'(eopq));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
